// File: rtl/operand_issue.sv
// Decode/issue stage: decodes 16-bit instructions, reads an 8x8 register file with writeback bypass,
// and stalls on a busy scoreboard; issues registered operands to the ALU one cycle after accept.
module operand_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [7:0]  wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  a,
  output logic [7:0]  b,
  output logic [2:0]  ctrl,
  output logic        flag,
  output logic [2:0]  rd,
  output logic        illegal
);

  logic [7:0] rf_q [8];
  logic [7:0] busy_q, busy_d;
  logic       out_valid_q, out_valid_d;
  logic [7:0] a_q, b_q;
  logic [2:0] ctrl_q, rd_q;
  logic       flag_q, illegal_q;

  logic [3:0] op;
  logic [2:0] f_rd, f_rs1, f_rs2;
  logic [5:0] imm6;
  logic [7:0] imm8;

  assign op    = in_instr[15:12];
  assign f_rd  = in_instr[11:9];
  assign f_rs1 = in_instr[8:6];
  assign f_rs2 = in_instr[5:3];
  assign imm6  = in_instr[5:0];
  assign imm8  = in_instr[7:0];

  logic       legal, use_rs1, use_rs2;
  logic [2:0] ctrl_dec;
  logic       flag_dec;

  always_comb begin
    legal    = 1'b1;
    use_rs1  = 1'b1;
    use_rs2  = 1'b1;
    ctrl_dec = 3'b000;
    flag_dec = 1'b0;
    case (op)
      4'h0: ;
      4'h1: flag_dec = 1'b1;
      4'h2: begin ctrl_dec = 3'b001; flag_dec = 1'b1; end
      4'h3: ctrl_dec = 3'b001;
      4'h4: ctrl_dec = 3'b010;
      4'h5: begin ctrl_dec = 3'b011; flag_dec = 1'b1; end
      4'h6: ctrl_dec = 3'b011;
      4'h7: ctrl_dec = 3'b100;
      4'h8: use_rs2 = 1'b0;
      4'h9: begin use_rs1 = 1'b0; use_rs2 = 1'b0; end
      default: begin legal = 1'b0; use_rs1 = 1'b0; use_rs2 = 1'b0; end
    endcase
  end

  // Register read with same-cycle writeback bypass; R0 is hardwired to zero.
  logic [7:0] rs1_val, rs2_val;

  always_comb begin
    rs1_val = rf_q[f_rs1];
    if (f_rs1 == 3'd0)
      rs1_val = 8'h00;
    else if (wb_en && wb_addr == f_rs1)
      rs1_val = wb_data;

    rs2_val = rf_q[f_rs2];
    if (f_rs2 == 3'd0)
      rs2_val = 8'h00;
    else if (wb_en && wb_addr == f_rs2)
      rs2_val = wb_data;
  end

  logic [7:0] a_dec, b_dec;

  always_comb begin
    a_dec = rs1_val;
    b_dec = rs2_val;
    if (op == 4'h8) begin
      b_dec = {{2{imm6[5]}}, imm6};
    end else if (op == 4'h9) begin
      a_dec = 8'h00;
      b_dec = imm8;
    end
  end

  // A register stops blocking in the cycle its writeback arrives.
  logic [7:0] blocked;
  logic       hazard;

  always_comb begin
    for (int i = 0; i < 8; i++)
      blocked[i] = busy_q[i] && !(wb_en && wb_addr == 3'(i));
    hazard = legal && ((use_rs1 && blocked[f_rs1]) ||
                       (use_rs2 && blocked[f_rs2]) ||
                       blocked[f_rd]);
  end

  logic accept, issue;

  assign in_ready = (!out_valid_q || out_ready) && !hazard;
  assign accept   = in_valid && in_ready;
  assign issue    = accept && legal;

  // Issue set is applied after writeback clear so it wins on the same register.
  always_comb begin
    busy_d = busy_q;
    if (wb_en)
      busy_d[wb_addr] = 1'b0;
    if (issue && f_rd != 3'd0)
      busy_d[f_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (issue)
      out_valid_d = 1'b1;
    else if (out_ready)
      out_valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++)
        rf_q[i] <= 8'h00;
      busy_q      <= 8'h00;
      out_valid_q <= 1'b0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      ctrl_q      <= 3'b000;
      flag_q      <= 1'b0;
      rd_q        <= 3'd0;
      illegal_q   <= 1'b0;
    end else begin
      if (wb_en && wb_addr != 3'd0)
        rf_q[wb_addr] <= wb_data;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      illegal_q   <= accept && !legal;
      if (issue) begin
        a_q    <= a_dec;
        b_q    <= b_dec;
        ctrl_q <= ctrl_dec;
        flag_q <= flag_dec;
        rd_q   <= f_rd;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign a         = a_q;
  assign b         = b_q;
  assign ctrl      = ctrl_q;
  assign flag      = flag_q;
  assign rd        = rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_operand_issue.sv
// Directed bench for operand_issue: hand-computed vectors for decode, bypass, hazards and backpressure.
module tb_operand_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_instr;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  a, b;
  logic [2:0]  ctrl, rd;
  logic        flag, illegal;

  int checks = 0;
  int errors = 0;

  operand_issue dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .ctrl(ctrl), .flag(flag), .rd(rd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input logic [15:0] instr,
                       input logic we, input logic [2:0] wa, input logic [7:0] wd);
    in_valid = vld;
    in_instr = instr;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                           input logic [2:0] ec, input logic ef, input logic [2:0] er);
    check({tag, ".vld"},  {31'd0, out_valid}, 32'd1);
    check({tag, ".a"},    {24'd0, a},    {24'd0, ea});
    check({tag, ".b"},    {24'd0, b},    {24'd0, eb});
    check({tag, ".ctrl"}, {29'd0, ctrl}, {29'd0, ec});
    check({tag, ".flag"}, {31'd0, flag}, {31'd0, ef});
    check({tag, ".rd"},   {29'd0, rd},   {29'd0, er});
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".vld"},  {31'd0, out_valid}, 32'd0);
    check({tag, ".a"},    {24'd0, a}, 32'd0);
    check({tag, ".b"},    {24'd0, b}, 32'd0);
    check({tag, ".ctrl"}, {29'd0, ctrl}, 32'd0);
    check({tag, ".flag"}, {31'd0, flag}, 32'd0);
    check({tag, ".rd"},   {29'd0, rd}, 32'd0);
    check({tag, ".ill"},  {31'd0, illegal}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 16'h0000, 1'b0, 3'd0, 8'h00);
    step(); step();
    rst = 1'b0;
    #1;
    check_reset("rst");
    check("rst.in_rdy", {31'd0, in_ready}, 32'd1);

    // ADD r1,r0,r0
    drive(1'b1, 16'h0200, 1'b0, 3'd0, 8'h00);
    check("add.in_rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("add", 8'h00, 8'h00, 3'b000, 1'b0, 3'd1);

    drive(1'b0, 16'h0000, 1'b1, 3'd1, 8'h00);
    step();
    check("drain.vld", {31'd0, out_valid}, 32'd0);

    // LI r2,0x5A
    drive(1'b1, 16'h945A, 1'b0, 3'd0, 8'h00);
    check("li.in_rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("li", 8'h00, 8'h5A, 3'b000, 1'b0, 3'd2);

    // SUB r3,r2,r2 stalls until r2 writeback, then takes the bypassed value
    drive(1'b1, 16'h1690, 1'b0, 3'd0, 8'h00);
    check("sub.stall", {31'd0, in_ready}, 32'd0);
    step();
    check("sub.stall.vld", {31'd0, out_valid}, 32'd0);
    drive(1'b1, 16'h1690, 1'b1, 3'd2, 8'h5A);
    check("sub.bypass.rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("sub", 8'h5A, 8'h5A, 3'b000, 1'b1, 3'd3);

    drive(1'b0, 16'h0000, 1'b1, 3'd3, 8'h00);
    step();
    drive(1'b0, 16'h0000, 1'b1, 3'd4, 8'h10);
    step();

    // ADDI r5,r4,0x3E -> b = 0xFE
    drive(1'b1, 16'h8B3E, 1'b0, 3'd0, 8'h00);
    check("addi.in_rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("addi", 8'h10, 8'hFE, 3'b000, 1'b0, 3'd5);

    // NAND r7,r2,r4 while r5 writes back
    drive(1'b1, 16'h2EA0, 1'b1, 3'd5, 8'h0E);
    check("nand.in_rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("nand", 8'h5A, 8'h10, 3'b001, 1'b1, 3'd7);

    // Backpressure: ADD r1,r2,r4 waits while the NAND result is held
    out_ready = 1'b0;
    drive(1'b1, 16'h02A0, 1'b0, 3'd0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      check("bp.in_rdy", {31'd0, in_ready}, 32'd0);
      step();
      check_out("bp.hold", 8'h5A, 8'h10, 3'b001, 1'b1, 3'd7);
    end
    out_ready = 1'b1;
    #1;
    check("bp.release.rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("bp.add", 8'h5A, 8'h10, 3'b000, 1'b0, 3'd1);

    // Illegal opcode consumed with a one-cycle pulse
    drive(1'b1, 16'hA123, 1'b0, 3'd0, 8'h00);
    check("ill.in_rdy", {31'd0, in_ready}, 32'd1);
    step();
    check("ill.vld", {31'd0, out_valid}, 32'd0);
    check("ill.pulse", {31'd0, illegal}, 32'd1);
    drive(1'b0, 16'h0000, 1'b0, 3'd0, 8'h00);
    step();
    check("ill.pulse.end", {31'd0, illegal}, 32'd0);

    // SRL r3,r1,r2: r1 still busy from the earlier ADD
    drive(1'b1, 16'h6650, 1'b0, 3'd0, 8'h00);
    check("srl.stall", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h6650, 1'b1, 3'd1, 8'h22);
    check("srl.rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("srl", 8'h22, 8'h5A, 3'b011, 1'b0, 3'd3);

    // LI r6,0x07 sets busy[6]
    drive(1'b1, 16'h9C07, 1'b1, 3'd3, 8'h00);
    step();
    check_out("li6", 8'h00, 8'h07, 3'b000, 1'b0, 3'd6);

    // SLL r6,r2,r4 blocked by WAW
    drive(1'b1, 16'h5CA0, 1'b0, 3'd0, 8'h00);
    check("waw.stall", {31'd0, in_ready}, 32'd0);
    step();
    check("waw.vld", {31'd0, out_valid}, 32'd0);

    // LI r6 issued alongside r6 writeback: busy[6] must remain set
    drive(1'b1, 16'h9C44, 1'b1, 3'd6, 8'h99);
    check("setclr.rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("setclr", 8'h00, 8'h44, 3'b000, 1'b0, 3'd6);
    drive(1'b1, 16'h5CA0, 1'b0, 3'd0, 8'h00);
    check("setclr.busy", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 16'h5CA0, 1'b1, 3'd6, 8'h44);
    check("sll.rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("sll", 8'h5A, 8'h10, 3'b011, 1'b1, 3'd6);

    // SLTU r0,r2,r4: flag forced low, rd=0 never marks busy
    drive(1'b1, 16'h40A0, 1'b0, 3'd0, 8'h00);
    step();
    check_out("sltu", 8'h5A, 8'h10, 3'b010, 1'b0, 3'd0);

    // SRA r1,r7,r0 stalls on r7; reset mid-stall clears everything
    drive(1'b1, 16'h73C0, 1'b0, 3'd0, 8'h00);
    check("sra.stall", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_reset("rst2");
    check("rst2.in_rdy", {31'd0, in_ready}, 32'd1);
    step();
    check_out("sra", 8'h00, 8'h00, 3'b100, 1'b0, 3'd1);

    drive(1'b0, 16'h0000, 1'b0, 3'd0, 8'h00);
    step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
